// File: rtl/sa_result_drain.sv
// Result drain for the output-stationary systolic array: snapshots the full result bus
// on start and streams it out one array row per valid/ready beat.
module sa_result_drain #(
    parameter int unsigned HPE   = 8,
    parameter int unsigned VPE   = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [2*WIDTH*HPE*VPE-1:0]                  y_in,
    output logic                                        acc_clr,
    output logic                                        busy,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [2*WIDTH*HPE-1:0]                      out_data,
    output logic [((VPE > 1) ? $clog2(VPE) : 1)-1:0]    out_row,
    output logic                                        out_last,
    output logic                                        overrun
);

    localparam int unsigned P_W   = 2 * WIDTH;
    localparam int unsigned N     = HPE * VPE;
    localparam int unsigned ROW_W = HPE * P_W;
    localparam int unsigned RW    = (VPE > 1) ? $clog2(VPE) : 1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    logic             state_q;
    logic [RW-1:0]    row_q;
    logic             acc_clr_q;
    logic             overrun_q;
    logic [N*P_W-1:0] buf_q;

    logic xfer;
    logic last_row;
    logic capture;
    logic start_ignored;

    always_comb begin
        xfer          = (state_q == ST_DRAIN) && out_ready;
        last_row      = (row_q == RW'(VPE - 1));
        // A start coinciding with the final handshake chains the next tile with no bubble.
        capture       = start && ((state_q == ST_IDLE) || (xfer && last_row));
        start_ignored = start && (state_q == ST_DRAIN) && !capture;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            acc_clr_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_clr_q <= capture;
            if (start_ignored) begin
                overrun_q <= 1'b1;
            end
            if (capture) begin
                state_q <= ST_DRAIN;
                row_q   <= '0;
            end else if (xfer) begin
                if (last_row) begin
                    state_q <= ST_IDLE;
                    row_q   <= '0;
                end else begin
                    row_q <= row_q + RW'(1);
                end
            end
        end
    end

    // Snapshot buffer has no reset; its contents only matter while draining.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= y_in;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_DRAIN);
        busy      = out_valid;
        acc_clr   = acc_clr_q;
        overrun   = overrun_q;
        out_row   = out_valid ? row_q : '0;
        out_last  = out_valid && last_row;
        out_data  = '0;
        if (out_valid) begin
            for (int unsigned r = 0; r < VPE; r++) begin
                if (row_q == RW'(r)) begin
                    out_data = buf_q[(VPE-r)*ROW_W-1 -: ROW_W];
                end
            end
        end
    end

endmodule
